// File: rtl/taiga_types.sv
// ============================================================================
//  Module      : taiga_types (package)
//  Description : Shared types and defaults for the fetch line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package taiga_types;

    // Default number of 32-bit words held in one line
    localparam int LB_LINE_WORDS_DEFAULT = 8;

    // Line buffer controller states
    typedef enum logic [2:0] {
        LB_IDLE   = 3'd0,
        LB_LOOKUP = 3'd1,
        LB_REQ    = 3'd2,
        LB_FILL   = 3'd3,
        LB_DRAIN  = 3'd4
    } lb_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_line_buffer_line_store.sv
// ============================================================================
//  Module      : lb_line_store
//  Description : Storage for one instruction line: word array, per-word
//                valid bits and the line tag. One write port (fill beats)
//                and one combinational read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lb_line_store
    import taiga_types::*;
#(
    parameter int LINE_WORDS = LB_LINE_WORDS_DEFAULT,
    parameter int LINE_W     = $clog2(LINE_WORDS),
    parameter int TAG_W      = 32 - LINE_W - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  tag_load,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic                  wr_en,
    input  logic [LINE_W-1:0]     wr_index,
    input  logic [31:0]           wr_data,
    input  logic [LINE_W-1:0]     rd_index,
    output logic [31:0]           rd_data,
    output logic [LINE_WORDS-1:0] word_valid,
    output logic [TAG_W-1:0]      tag
);

    logic [31:0] data [LINE_WORDS];

    // Word array: plain storage, contents qualified by word_valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[wr_index] <= wr_data;
        end
    end

    // Per-word valid bits: cleared when a new line is started
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_valid <= '0;
        end else if (clear) begin
            word_valid <= '0;
        end else if (wr_en) begin
            word_valid[wr_index] <= 1'b1;
        end
    end

    // Tag register, loaded when a miss starts a new line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag <= '0;
        end else if (tag_load) begin
            tag <= tag_in;
        end
    end

    assign rd_data = data[rd_index];

endmodule

`default_nettype wire

// File: rtl/fetch_line_buffer.sv
// ============================================================================
//  Module      : fetch_line_buffer
//  Description : Fetch sub-unit holding a single instruction line, filled by
//                a line-aligned burst over the L1 arbiter path. Hits return
//                one word per cycle, one cycle after the request.
//                Optional macro FETCH_LB_EARLY_RESTART_EN: return the
//                requested word as soon as its beat arrives during a fill
//                instead of after the final beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_line_buffer
    import taiga_types::*;
#(
    parameter int LINE_WORDS = LB_LINE_WORDS_DEFAULT,
    parameter int LINE_W     = $clog2(LINE_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_request,
    input  logic [31:0] stage1_addr,
    input  logic [31:0] stage2_addr,
    input  logic        flush,
    output logic        ready,
    output logic        data_valid,
    output logic [31:0] data_out,
    output logic        l1_req_valid,
    output logic [31:0] l1_req_addr,
    output logic [4:0]  l1_req_len,
    input  logic        l1_req_ack,
    input  logic        l1_rd_valid,
    input  logic [31:0] l1_rd_data
);

    localparam int TAG_W = 32 - LINE_W - 2;

    lb_state_t             state;
    lb_state_t             next_state;
    logic                  line_valid;
    logic [LINE_W-1:0]     fill_cnt;
    logic [LINE_W-1:0]     req_index;
    logic                  resp_pending;
    logic [31:0]           resp_data;

    logic [TAG_W-1:0]      lookup_tag;
    logic [LINE_W-1:0]     lookup_index;
    logic [TAG_W-1:0]      tag;
    logic [LINE_WORDS-1:0] word_valid;
    logic [LINE_W-1:0]     rd_index;
    logic [31:0]           rd_data;
    logic                  hit;
    logic                  beat;
    logic                  beat_last;
    logic                  miss_start;
    logic                  lookup_valid;
    logic                  resp_set;
    logic [31:0]           resp_word;

    // The fetch side's stage-1 address and the byte offset are not needed here
    logic                  unused_bits;
    assign unused_bits = ^{stage1_addr, stage2_addr[1:0]};

    assign lookup_tag   = stage2_addr[31:LINE_W+2];
    assign lookup_index = stage2_addr[LINE_W+1:2];
    assign hit          = line_valid && (tag == lookup_tag) && word_valid[lookup_index];
    assign beat         = l1_rd_valid && ((state == LB_FILL) || (state == LB_DRAIN));
    assign beat_last    = (fill_cnt == LINE_W'(LINE_WORDS - 1));
    assign rd_index     = (state == LB_LOOKUP) ? lookup_index : req_index;

    lb_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .LINE_W     (LINE_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .clear      (miss_start),
        .tag_load   (miss_start),
        .tag_in     (lookup_tag),
        .wr_en      (beat),
        .wr_index   (fill_cnt),
        .wr_data    (l1_rd_data),
        .rd_index   (rd_index),
        .rd_data    (rd_data),
        .word_valid (word_valid),
        .tag        (tag)
    );

    // Next-state and handshake decode
    always_comb begin
        next_state   = state;
        ready        = 1'b0;
        lookup_valid = 1'b0;
        miss_start   = 1'b0;
        unique case (state)
            LB_IDLE: begin
                ready = 1'b1;
                if (new_request) begin
                    next_state = LB_LOOKUP;
                end
            end
            LB_LOOKUP: begin
                if (flush) begin
                    next_state = LB_IDLE;
                end else if (hit) begin
                    ready        = 1'b1;
                    lookup_valid = 1'b1;
                    next_state   = new_request ? LB_LOOKUP : LB_IDLE;
                end else begin
                    miss_start = 1'b1;
                    next_state = LB_REQ;
                end
            end
            LB_REQ: begin
                if (l1_req_ack) begin
                    next_state = flush ? LB_DRAIN : LB_FILL;
                end else if (flush) begin
                    next_state = LB_IDLE;
                end
            end
            LB_FILL: begin
                if (beat && beat_last) begin
                    next_state = LB_IDLE;
                end else if (flush) begin
                    next_state = LB_DRAIN;
                end
            end
            LB_DRAIN: begin
                if (beat && beat_last) begin
                    next_state = LB_IDLE;
                end
            end
            default: next_state = LB_IDLE;
        endcase
    end

    // Decide when a fill delivers the requested word, and which word
    always_comb begin
        resp_set  = 1'b0;
        resp_word = l1_rd_data;
`ifdef FETCH_LB_EARLY_RESTART_EN
        if ((state == LB_FILL) && beat && !flush && (fill_cnt == req_index)) begin
            resp_set = 1'b1;
        end
`else
        if ((state == LB_FILL) && beat && !flush && beat_last) begin
            resp_set  = 1'b1;
            resp_word = (req_index == fill_cnt) ? l1_rd_data : rd_data;
        end
`endif
    end

    // State register, line status, fill counter and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LB_IDLE;
            line_valid   <= 1'b0;
            fill_cnt     <= '0;
            req_index    <= '0;
            resp_pending <= 1'b0;
            resp_data    <= '0;
        end else begin
            state        <= next_state;
            resp_pending <= resp_set;
            if (resp_set) begin
                resp_data <= resp_word;
            end
            if (miss_start) begin
                line_valid <= 1'b0;
                req_index  <= lookup_index;
                fill_cnt   <= '0;
            end
            if ((state == LB_REQ) && l1_req_ack) begin
                fill_cnt <= '0;
            end
            if (beat) begin
                fill_cnt <= fill_cnt + LINE_W'(1);
                if (beat_last) begin
                    line_valid <= 1'b1;
                end
            end
        end
    end

    // A flush cancels a response that would land in the same cycle
    assign data_valid   = lookup_valid || (resp_pending && !flush);
    assign data_out     = (state == LB_LOOKUP) ? rd_data : resp_data;
    assign l1_req_valid = (state == LB_REQ);
    assign l1_req_addr  = {tag, {(LINE_W + 2){1'b0}}};
    assign l1_req_len   = 5'(LINE_WORDS - 1);

    // Return beats are only legal while a fill is expected
    a_no_orphan_beat : assert property (@(posedge clk) disable iff (rst)
        !(l1_rd_valid && (state inside {LB_IDLE, LB_LOOKUP, LB_REQ})));

    // Requests only while ready, never together with a flush
    a_req_when_ready : assert property (@(posedge clk) disable iff (rst)
        !(new_request && !ready));

    a_no_req_with_flush : assert property (@(posedge clk) disable iff (rst)
        !(new_request && flush));

endmodule

`default_nettype wire

// File: doc/fetch_line_buffer.md
Name: fetch_line_buffer

Overview:
- Responder (sub-unit) side of the fetch sub-unit protocol: accepts fetch requests, returns one 32-bit instruction word per request.
- Holds one instruction line of LINE_WORDS words, filled by a line-aligned burst over the L1 arbiter request/return path.
- Sits beside the scratch-RAM and icache sub-units as a low-area alternative for uncached or external instruction regions.

Parameters:
- LINE_WORDS, 8: words per line; power of two, 2..16.
- LINE_W, $clog2(LINE_WORDS): word-index width, derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- new_request  in  1  fetch request; asserted only while ready=1
- stage1_addr  in  32  physical address, valid with new_request
- stage2_addr  in  32  same address, one cycle later (registered by the fetch side)
- flush  in  1  abort the in-flight request
- ready  out  1  can accept new_request this cycle
- data_valid  out  1  data_out holds the requested word; one-cycle pulse per request
- data_out  out  32  instruction word
- l1_req_valid  out  1  burst read request
- l1_req_addr  out  32  line-aligned address, low log2(LINE_WORDS)+2 bits zero
- l1_req_len  out  5  burst length, LINE_WORDS-1
- l1_req_ack  in  1  arbiter accepted the request
- l1_rd_valid  in  1  return word valid; words arrive in ascending order
- l1_rd_data  in  32  return word

Behaviour:
- Address split: tag = addr[31:LINE_W+2]; index = addr[LINE_W+1:2]; addr[1:0] ignored.
- State: tag_r, line_valid, word_valid[LINE_WORDS], data array, fill_cnt[LINE_W-1:0].
- Reset values: state IDLE, line_valid=0, word_valid=0, ready=1, data_valid=0, l1_req_valid=0, data_out=0, fill_cnt=0.
- FSM states: IDLE, LOOKUP, REQ, FILL, DRAIN.
- IDLE, ready=1: new_request -> LOOKUP. stage1_addr is not registered locally; stage2_addr is used for the tag compare.
- LOOKUP, hit (line_valid & tag match & word_valid[index]):
  - data_valid=1 and data_out=word in this cycle, i.e. 1 cycle after new_request.
  - ready=1; a new_request in this same cycle stays in LOOKUP. Sustained throughput is 1 word/cycle.
- LOOKUP, miss: ready=0.
  - Latch tag_r and req_index; clear line_valid and word_valid.
  - Assert l1_req_valid with the line-aligned address -> REQ.
- REQ: hold l1_req_valid, l1_req_addr and l1_req_len stable until l1_req_ack. The ack cycle deasserts l1_req_valid -> FILL with fill_cnt=0.
- FILL: on each l1_rd_valid, write data[fill_cnt], set word_valid[fill_cnt], increment fill_cnt.
  - Response timing depends on FETCH_LB_EARLY_RESTART_EN.
  - Last word (fill_cnt == LINE_WORDS-1): line_valid=1 -> IDLE, ready=1.
- data_valid rules:
  - Asserted exactly once per accepted, unflushed request.
  - Never asserted in REQ or DRAIN.
  - Never asserted in the same cycle as flush.
- Flush:
  - LOOKUP: suppress data_valid -> IDLE.
  - REQ before ack: drop l1_req_valid -> IDLE, line_valid=0.
  - REQ in the ack cycle: -> DRAIN.
  - FILL: -> DRAIN.
  - DRAIN: keep storing words, ready=0. After the last word, set line_valid=1 -> IDLE. The filled line stays usable.
- Simultaneous flush and new_request cannot occur (the fetch side gates new_request). Flush in IDLE is a no-op.
- Reset mid-fill: all state cleared asynchronously. The L1 arbiter shares rst, so no orphan beats arrive.
- fill_cnt wraps to 0 after the last word; excess l1_rd_valid in IDLE is a protocol error and is covered by an assertion.

Optional Feature:
- FETCH_LB_EARLY_RESTART_EN defined:
  - In FILL, data_valid pulses in the cycle after the beat with fill_cnt == req_index. data_out is the registered beat.
  - ready stays 0 until the fill completes.
- Undefined: data_valid pulses in the cycle after the final beat, with data_out read from the array at req_index.
- Both variants: exactly one data_valid per request.

Decomposition:
- Shared package (taiga_types): typedef lb_state_t (enum of the five states); localparam LB_LINE_WORDS_DEFAULT.
- Assertions reuse the existing assertion style.
- Natural sub-module: lb_line_store, holding the data array, word_valid vector and tag register. It has a write port (fill) and a read port (index) and keeps the FSM file under 300 lines.

Test Plan:
- Cold miss: rst, request 0x8000_0014 -> l1_req_addr=0x8000_0000, len=7. Return 0x00000013+i for i=0..7.
  - Early restart on: data_valid=1, data_out=0x00000018 one cycle after beat 5.
  - Early restart off: same data one cycle after beat 7.
- Back-to-back hits: after the fill, requests 0x8000_0000..0x8000_001C on consecutive cycles -> 8 data_valid pulses on consecutive cycles, words 0x13..0x1A, no l1_req_valid.
- Tag change: request 0x8000_0020 -> miss, l1_req_addr=0x8000_0020. The old line is invalid afterwards: re-request 0x8000_0000 -> miss.
- Flush in FILL at beat 3 -> no data_valid; ready=0 until beat 7; then request 0x8000_0004 -> hit, 1-cycle latency.
- Flush in REQ with l1_req_ack held low -> l1_req_valid drops next cycle, ready=1, no data_valid, the next request misses.
- Async reset asserted mid-FILL, between clock edges -> ready=1, data_valid=0, l1_req_valid=0 immediately; the next request misses.
